// File: rtl/exec_pkg.sv
// Shared EXEC-stage definitions: complex-op opcodes, flag bit indices,
// controller state encoding and per-opcode latency lookup.
package exec_pkg;

    localparam logic [7:0] MULT_L  = 8'h18;
    localparam logic [7:0] MULT_H  = 8'h19;
    localparam logic [7:0] MULTU_L = 8'h1A;
    localparam logic [7:0] MULTU_H = 8'h1B;
    localparam logic [7:0] DIV_L   = 8'h1C;
    localparam logic [7:0] DIV_H   = 8'h1D;
    localparam logic [7:0] DIVU_L  = 8'h1E;
    localparam logic [7:0] DIVU_H  = 8'h1F;
    localparam logic [7:0] SYSCALL = 8'h0C;

    localparam int EXECUTED   = 2;
    localparam int EXCEPTION  = 1;
    localparam int MISPREDICT = 0;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        DONE
    } state_t;

    function automatic logic is_div(input logic [7:0] op);
        return (op == DIV_L) || (op == DIV_H) ||
               (op == DIVU_L) || (op == DIVU_H);
    endfunction

    function automatic int op_latency(
        input logic [7:0] op,
        input int         mul_lat,
        input int         div_lat
    );
        case (op)
            MULT_L, MULT_H, MULTU_L, MULTU_H: return mul_lat;
            DIV_L, DIV_H, DIVU_L, DIVU_H:     return div_lat;
            default:                          return 1;
        endcase
    endfunction

endpackage

// File: rtl/complex_alu_ctrl.sv
// Multi-cycle sequencer around Complex_ALU: holds operands for the
// opcode latency, captures the result and hands it to writeback.
module complex_alu_ctrl
    import exec_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int IMM_W   = 16,
    parameter int OPC_W   = 8,
    parameter int FLAG_W  = 6,
    parameter int TAG_W   = 7,
    parameter int MUL_LAT = 3,
    parameter int DIV_LAT = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush_i,
    input  logic                issue_valid_i,
    output logic                issue_ready_o,
    input  logic [OPC_W-1:0]    opcode_i,
    input  logic [DATA_W-1:0]   data1_i,
    input  logic [DATA_W-1:0]   data2_i,
    input  logic [IMM_W-1:0]    immd_i,
    input  logic [TAG_W-1:0]    tag_i,
    output logic [OPC_W-1:0]    alu_opcode_o,
    output logic [DATA_W-1:0]   alu_data1_o,
    output logic [DATA_W-1:0]   alu_data2_o,
    output logic [IMM_W-1:0]    alu_immd_o,
    input  logic [2*DATA_W-1:0] alu_result_i,
    input  logic [FLAG_W-1:0]   alu_flags_i,
    output logic                wb_valid_o,
    input  logic                wb_ready_i,
    output logic [TAG_W-1:0]    wb_tag_o,
    output logic [2*DATA_W-1:0] wb_result_o,
    output logic [FLAG_W-1:0]   wb_flags_o,
    output logic                busy_o
);

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             div_zero;

    assign issue_ready_o = !flush_i &&
        ((state == IDLE) || ((state == DONE) && wb_ready_i));
    assign accept   = issue_valid_i && issue_ready_o;
    assign busy_o   = (state != IDLE);
    assign div_zero = is_div(8'(alu_opcode_o)) && (alu_data2_o == '0);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            cnt          <= '0;
            alu_opcode_o <= '0;
            alu_data1_o  <= '0;
            alu_data2_o  <= '0;
            alu_immd_o   <= '0;
            wb_valid_o   <= 1'b0;
            wb_tag_o     <= '0;
            wb_result_o  <= '0;
            wb_flags_o   <= '0;
        end else if (flush_i) begin
            state      <= IDLE;
            cnt        <= '0;
            wb_valid_o <= 1'b0;
        end else if (accept) begin
            // Covers both IDLE issue and the DONE->EXEC back-to-back path.
            alu_opcode_o <= opcode_i;
            alu_data1_o  <= data1_i;
            alu_data2_o  <= data2_i;
            alu_immd_o   <= immd_i;
            wb_tag_o     <= tag_i;
            cnt          <= CNT_W'(op_latency(8'(opcode_i), MUL_LAT, DIV_LAT) - 1);
            wb_valid_o   <= 1'b0;
            state        <= EXEC;
        end else begin
            case (state)
                EXEC: begin
                    if (cnt == '0) begin
                        wb_result_o <= div_zero ? '0 : alu_result_i;
                        wb_flags_o  <= alu_flags_i |
                            (div_zero ? (FLAG_W'(1) << EXCEPTION) : '0);
                        wb_valid_o  <= 1'b1;
                        state       <= DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    if (wb_ready_i) begin
                        wb_valid_o <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_complex_alu_ctrl.sv
// Randomised self-checking bench for complex_alu_ctrl with a behavioural
// Complex_ALU and a packet-level reference model.
module tb_complex_alu_ctrl;
    import exec_pkg::*;

    localparam int MUL_LAT = 3;
    localparam int DIV_LAT = 16;

    logic        clk;
    logic        reset;
    logic        flush_i;
    logic        issue_valid_i;
    logic        issue_ready_o;
    logic [7:0]  opcode_i;
    logic [31:0] data1_i;
    logic [31:0] data2_i;
    logic [15:0] immd_i;
    logic [6:0]  tag_i;
    logic [7:0]  alu_opcode_o;
    logic [31:0] alu_data1_o;
    logic [31:0] alu_data2_o;
    logic [15:0] alu_immd_o;
    logic [63:0] alu_result_i;
    logic [5:0]  alu_flags_i;
    logic        wb_valid_o;
    logic        wb_ready_i;
    logic [6:0]  wb_tag_o;
    logic [63:0] wb_result_o;
    logic [5:0]  wb_flags_o;
    logic        busy_o;

    int tests = 0;
    int fails = 0;

    logic [7:0] ops [9] = '{MULT_L, MULT_H, MULTU_L, MULTU_H,
                            DIV_L, DIV_H, DIVU_L, DIVU_H, SYSCALL};

    complex_alu_ctrl #(
        .DATA_W(32), .IMM_W(16), .OPC_W(8), .FLAG_W(6), .TAG_W(7),
        .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)
    ) dut (
        .clk(clk), .reset(reset), .flush_i(flush_i),
        .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
        .opcode_i(opcode_i), .data1_i(data1_i), .data2_i(data2_i),
        .immd_i(immd_i), .tag_i(tag_i),
        .alu_opcode_o(alu_opcode_o), .alu_data1_o(alu_data1_o),
        .alu_data2_o(alu_data2_o), .alu_immd_o(alu_immd_o),
        .alu_result_i(alu_result_i), .alu_flags_i(alu_flags_i),
        .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i),
        .wb_tag_o(wb_tag_o), .wb_result_o(wb_result_o),
        .wb_flags_o(wb_flags_o), .busy_o(busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic is_d(input logic [7:0] op);
        return op inside {DIV_L, DIV_H, DIVU_L, DIVU_H};
    endfunction

    function automatic int exp_lat(input logic [7:0] op);
        if (op inside {MULT_L, MULT_H, MULTU_L, MULTU_H}) return MUL_LAT;
        if (is_d(op)) return DIV_LAT;
        return 1;
    endfunction

    // Behavioural ALU; divide-by-zero yields junk the controller must hide.
    function automatic logic [63:0] alu_fn(input logic [7:0] op,
        input logic [31:0] a, input logic [31:0] b, input logic [15:0] im);
        longint sa, sb, q, r;
        longint unsigned ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        if (op inside {MULT_L, MULT_H}) return 64'(sa * sb);
        if (op inside {MULTU_L, MULTU_H}) return ua * ub;
        if (is_d(op)) begin
            if (b == 0) return 64'hDEAD_BEEF_0BAD_F00D;
            if (op inside {DIV_L, DIV_H}) begin
                q = sa / sb;
                r = sa % sb;
            end else begin
                q = longint'(ua / ub);
                r = longint'(ua % ub);
            end
            return {r[31:0], q[31:0]};
        end
        return {a + {16'b0, im}, b ^ {24'b0, op}};
    endfunction

    function automatic logic [5:0] fl_fn(input logic [31:0] a);
        return {3'b000, 1'b1, 1'b0, ^a};
    endfunction

    function automatic logic [63:0] exp_res(input logic [7:0] op,
        input logic [31:0] a, input logic [31:0] b, input logic [15:0] im);
        if (is_d(op) && b == 0) return 64'h0;
        return alu_fn(op, a, b, im);
    endfunction

    function automatic logic [5:0] exp_fl(input logic [7:0] op,
        input logic [31:0] a, input logic [31:0] b);
        if (is_d(op) && b == 0) return fl_fn(a) | 6'b000010;
        return fl_fn(a);
    endfunction

    always_comb begin
        alu_result_i = alu_fn(alu_opcode_o, alu_data1_o, alu_data2_o, alu_immd_o);
        alu_flags_i  = fl_fn(alu_data1_o);
    end

    task automatic do_issue(input logic [7:0] op, input logic [31:0] a,
        input logic [31:0] b, input logic [15:0] im, input logic [6:0] tg);
        @(negedge clk);
        opcode_i = op; data1_i = a; data2_i = b; immd_i = im; tag_i = tg;
        issue_valid_i = 1'b1;
        #1;
        tests++;
        if (issue_ready_o !== 1'b1) begin
            fails++;
            $display("FAIL issue_ready got %b want 1", issue_ready_o);
        end
        @(posedge clk);
        #1;
        issue_valid_i = 1'b0;
        opcode_i = 8'($urandom); data1_i = $urandom; data2_i = $urandom;
        immd_i = 16'($urandom); tag_i = 7'($urandom);
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (n < 100) begin
            @(negedge clk);
            n++;
            if (wb_valid_o === 1'b1) break;
        end
    endtask

    task automatic handshake();
        wb_ready_i = 1'b1;
        @(negedge clk);
        wb_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; flush_i = 1'b0; issue_valid_i = 1'b0; wb_ready_i = 1'b0;
        opcode_i = '0; data1_i = '0; data2_i = '0; immd_i = '0; tag_i = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        tests++;
        if ({issue_ready_o, busy_o, wb_valid_o} !== 3'b100) begin
            fails++;
            $display("FAIL reset_ctrl got rdy/busy/val=%b want 100",
                {issue_ready_o, busy_o, wb_valid_o});
        end
        tests++;
        if ({alu_opcode_o, alu_data1_o, alu_data2_o, alu_immd_o,
             wb_tag_o, wb_result_o, wb_flags_o} !== '0) begin
            fails++;
            $display("FAIL reset_data got nonzero alu/wb outputs want 0");
        end
    endtask

    task automatic test_mult();
        int nb, vi;
        logic [6:0]  tg;
        logic [31:0] lo;
        nb = 0; vi = 0; tg = '0; lo = '0;
        wb_ready_i = 1'b1;
        do_issue(MULT_L, 32'd7, -32'sd3, 16'd0, 7'd5);
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (busy_o) nb++;
            if (wb_valid_o && vi == 0) begin
                vi = i; tg = wb_tag_o; lo = wb_result_o[31:0];
            end
        end
        wb_ready_i = 1'b0;
        tests++;
        if (nb != 4) begin
            fails++; $display("FAIL mult_busy got %0d want 4", nb);
        end
        tests++;
        if (vi != 4) begin
            fails++; $display("FAIL mult_latency got %0d want 4", vi);
        end
        tests++;
        if (tg !== 7'd5 || lo !== 32'hFFFF_FFEB) begin
            fails++;
            $display("FAIL mult_data got tag=%0d lo=%h want 5 ffffffeb", tg, lo);
        end
    endtask

    task automatic test_divu();
        int n;
        do_issue(DIVU_L, 32'd100, 32'd7, 16'd0, 7'd11);
        wait_valid(n);
        tests++;
        if (n != 17) begin
            fails++; $display("FAIL divu_latency got %0d want 17", n);
        end
        tests++;
        if (wb_result_o[31:0] !== 32'd14 || wb_flags_o[1] !== 1'b0 ||
            wb_tag_o !== 7'd11) begin
            fails++;
            $display("FAIL divu_data got q=%0d exc=%b tag=%0d want 14 0 11",
                wb_result_o[31:0], wb_flags_o[1], wb_tag_o);
        end
        handshake();
    endtask

    task automatic test_div_zero();
        int n;
        logic [31:0] a;
        a = $urandom;
        do_issue(DIV_L, a, 32'd0, 16'h1234, 7'd22);
        wait_valid(n);
        tests++;
        if (n != 17) begin
            fails++; $display("FAIL divz_latency got %0d want 17", n);
        end
        tests++;
        if (wb_result_o !== 64'h0 || wb_flags_o !== exp_fl(DIV_L, a, 32'd0)) begin
            fails++;
            $display("FAIL divz_data got res=%h fl=%b want 0 %b",
                wb_result_o, wb_flags_o, exp_fl(DIV_L, a, 32'd0));
        end
        handshake();
    endtask

    task automatic test_backpressure();
        int n, bad;
        logic [63:0] r;
        logic [5:0]  f;
        logic [6:0]  t;
        logic [31:0] a, b;
        bad = 0;
        do_issue(MULTU_H, 32'hFFFF_0001, 32'h0001_0003, 16'd0, 7'd33);
        wait_valid(n);
        r = wb_result_o; f = wb_flags_o; t = wb_tag_o;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!wb_valid_o || wb_result_o !== r || wb_flags_o !== f ||
                wb_tag_o !== t || issue_ready_o !== 1'b0) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++; $display("FAIL hold_stable got %0d bad cycles want 0", bad);
        end
        tests++;
        if (r !== exp_res(MULTU_H, 32'hFFFF_0001, 32'h0001_0003, 16'd0)) begin
            fails++; $display("FAIL multu_data got %h want %h", r,
                exp_res(MULTU_H, 32'hFFFF_0001, 32'h0001_0003, 16'd0));
        end
        a = $urandom; b = $urandom;
        wb_ready_i = 1'b1; issue_valid_i = 1'b1;
        opcode_i = SYSCALL; data1_i = a; data2_i = b; immd_i = 16'h00FF; tag_i = 7'd9;
        #1;
        tests++;
        if (issue_ready_o !== 1'b1) begin
            fails++; $display("FAIL b2b_ready got %b want 1", issue_ready_o);
        end
        @(posedge clk);
        #1;
        wb_ready_i = 1'b0; issue_valid_i = 1'b0; data1_i = ~a;
        wait_valid(n);
        tests++;
        if (n != 2 || wb_tag_o !== 7'd9 ||
            wb_result_o !== exp_res(SYSCALL, a, b, 16'h00FF)) begin
            fails++;
            $display("FAIL b2b_syscall got n=%0d tag=%0d res=%h want 2 9 %h",
                n, wb_tag_o, wb_result_o, exp_res(SYSCALL, a, b, 16'h00FF));
        end
        handshake();
    endtask

    task automatic test_flush();
        int bad;
        bad = 0;
        do_issue(DIV_L, 32'd1000, 32'd3, 16'd0, 7'd44);
        repeat (5) @(negedge clk);
        flush_i = 1'b1; issue_valid_i = 1'b1; opcode_i = SYSCALL; tag_i = 7'd45;
        #1;
        tests++;
        if (issue_ready_o !== 1'b0) begin
            fails++; $display("FAIL flush_ready got %b want 0", issue_ready_o);
        end
        @(posedge clk);
        #1;
        flush_i = 1'b0; issue_valid_i = 1'b0;
        @(negedge clk);
        tests++;
        if (busy_o !== 1'b0 || issue_ready_o !== 1'b1) begin
            fails++;
            $display("FAIL flush_idle got busy=%b rdy=%b want 0 1", busy_o, issue_ready_o);
        end
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (wb_valid_o !== 1'b0 || busy_o !== 1'b0) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++; $display("FAIL flush_no_wb got %0d bad cycles want 0", bad);
        end
    endtask

    task automatic test_reset_mid();
        do_issue(DIVU_H, 32'd55, 32'd4, 16'h0F0F, 7'd66);
        repeat (5) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        tests++;
        if ({issue_ready_o, busy_o, wb_valid_o} !== 3'b100 ||
            {alu_opcode_o, alu_data1_o, alu_data2_o, alu_immd_o,
             wb_tag_o, wb_result_o, wb_flags_o} !== '0) begin
            fails++;
            $display("FAIL reset_mid got rdy/busy/val=%b op=%h tag=%0d want 100 0 0",
                {issue_ready_o, busy_o, wb_valid_o}, alu_opcode_o, wb_tag_o);
        end
        repeat (20) @(negedge clk);
        tests++;
        if (wb_valid_o !== 1'b0) begin
            fails++; $display("FAIL reset_discard got valid=%b want 0", wb_valid_o);
        end
    endtask

    task automatic test_random();
        int n, errs;
        logic [7:0]  op;
        logic [31:0] a, b;
        logic [15:0] im;
        logic [6:0]  tg;
        errs = 0;
        for (int k = 0; k < 40; k++) begin
            op = ($urandom_range(0, 9) == 9) ? 8'($urandom) : ops[$urandom_range(0, 8)];
            a  = $urandom;
            b  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            im = 16'($urandom);
            tg = 7'($urandom);
            do_issue(op, a, b, im, tg);
            wait_valid(n);
            tests++;
            if (n != exp_lat(op) + 1 || wb_tag_o !== tg ||
                wb_result_o !== exp_res(op, a, b, im) ||
                wb_flags_o !== exp_fl(op, a, b)) begin
                fails++; errs++;
                if (errs < 6)
                    $display("FAIL rand_op%0d op=%h got n=%0d res=%h fl=%b want n=%0d res=%h fl=%b",
                        k, op, n, wb_result_o, wb_flags_o, exp_lat(op) + 1,
                        exp_res(op, a, b, im), exp_fl(op, a, b));
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
            handshake();
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_divu();
        test_div_zero();
        test_backpressure();
        test_flush();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
